kwta_gamma_ctrl: RTL and testbench
==================================

Name: kwta_gamma_ctrl

Overview:
- Clocked sequencer for a kwta column. It divides time into gamma cycles of GAMMA_CYCLE_WIDTH clocks.
- At the start of each cycle it drives the column reset (kwta rst) high for RST_CYCLES clocks.
- For the rest of the cycle it accumulates which column outputs spiked.
- At cycle end it publishes the winner mask, a popcount and a gamma index over a valid/ready handshake to the downstream learning/readout logic.

Parameters:
- GAMMA_CYCLE_WIDTH, 16: clocks per gamma cycle (reset phase plus sample phase). Legal range >= RST_CYCLES+1.
- RST_CYCLES, 2: clocks col_rst is held high at cycle start. Legal range 1 to GAMMA_CYCLE_WIDTH-1.
- NUM_INPUTS, 16: column width; must match the kwta NUM_INPUTS.
- K, 4: kwta winner limit, used only for the excess flag.
- IDX_WIDTH, 16: width of the gamma cycle index.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable
- col_spikes  in  NUM_INPUTS  kwta output_spikes; level or pulse, sampled every clk
- col_rst  out  1  drives the kwta rst input; high = column cleared
- gamma_start  out  1  one-clk pulse on the first clock of each reset phase
- winners  out  NUM_INPUTS  published winner mask
- win_count  out  $clog2(NUM_INPUTS+1)  popcount of winners
- excess  out  1  win_count > K (tie overflow in the column)
- gamma_idx  out  IDX_WIDTH  index of the published cycle
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts
- overrun  out  1  sticky; an unconsumed result was overwritten
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - state=IDLE, phase=0, col_rst=1, gamma_start=0.
  - accumulator=0, winners=0, win_count=0, excess=0.
  - gamma_idx=0, result_valid=0, overrun=0.
- States:
  - IDLE: col_rst=1, accumulator held at 0. If en=1 at a clock edge, go to RST with phase=0 and gamma_start=1 for that clock.
  - RST: col_rst=1, accumulator cleared. phase increments every clock. After RST_CYCLES clocks (phase==RST_CYCLES-1), go to SAMPLE.
  - SAMPLE: col_rst=0, accumulator |= col_spikes every clock, phase increments. On the clock where phase==GAMMA_CYCLE_WIDTH-1, the spikes of that clock are included. At that edge:
    - winners gets the final OR.
    - win_count gets its popcount; excess gets (popcount > K).
    - gamma_idx gets the internal cycle counter, which then increments and wraps modulo 2^IDX_WIDTH.
    - result_valid is set to 1.
    - Next state is RST (phase=0, gamma_start=1) if en=1, else IDLE.
- Cycle length is exactly GAMMA_CYCLE_WIDTH clocks, with back-to-back cycles and no gap clock.
- Latency: result_valid rises on the clock after the last sample clock.
- Deasserting en mid-cycle does not abort the cycle; it completes and publishes, then goes to IDLE. Re-asserting en in IDLE starts a fresh cycle at phase 0.
- Handshake:
  - Transfer occurs on a clock with result_valid & result_ready.
  - result_valid and all result fields are held stable until that transfer.
  - After a transfer, result_valid=0 unless a publish occurs on the same edge.
- Publish while result_valid=1 and no transfer on that edge: the new result overwrites the old one, result_valid stays 1, and overrun is set.
- Publish on the same edge as a transfer: the new result is loaded, result_valid stays 1, and there is no overrun.
- overrun_clr clears overrun. If a set and a clear happen on the same edge, set wins.
- col_spikes arriving while col_rst=1 are ignored.
- Spikes present on the first SAMPLE clock are counted.
- gamma_idx wrap: after value 2^IDX_WIDTH-1, the next published index is 0.
- Phase counter width: $clog2(GAMMA_CYCLE_WIDTH).
- popcount is computed combinationally from the accumulator and registered only at publish.
- Asserting rst_n low mid-cycle returns everything to the reset values immediately. Any pending result is lost, and col_rst goes high asynchronously.

Test Plan:
- Reset then en=1 held, col_spikes=0: col_rst high for 2 clks and low for 14; gamma_start pulses every 16 clks; result_valid after clk 16 with winners=0, win_count=0, gamma_idx=0, then gamma_idx=1 and 2 on the next publishes.
- Spikes on bits 3,7 at sample clk 5 and bit 0 on the last sample clk, result_ready=1: winners=0x0089, win_count=3, excess=0. A spike on bit 9 during RST is ignored.
- Five bits spike on the same clock (tie), K=4: win_count=5, excess=1.
- result_ready=0 for 2 cycles: the first result is held, the second overwrites it, overrun=1. overrun_clr pulse then gives overrun=0. Setting result_ready=1 on the publish edge instead gives no overrun.
- en dropped at phase 6: the cycle completes and publishes, state goes to IDLE with col_rst=1 and no further gamma_start. en re-raised: the next cycle starts at phase 0 with gamma_start=1.
- rst_n pulsed low at phase 9: col_rst=1 and result_valid=0 immediately; gamma_idx restarts at 0.

Source files
------------

// File: rtl/kwta_gamma_ctrl.sv
// Gamma-cycle sequencer for a kwta column: holds the column in reset, ORs the
// column spikes over the sample window and publishes the winner mask per cycle.
module kwta_gamma_ctrl #(
   parameter int GAMMA_CYCLE_WIDTH = 16,
   parameter int RST_CYCLES        = 2,
   parameter int NUM_INPUTS        = 16,
   parameter int K                 = 4,
   parameter int IDX_WIDTH         = 16,
   localparam int CW               = $clog2(NUM_INPUTS + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [NUM_INPUTS-1:0] col_spikes,
   output logic                  col_rst,
   output logic                  gamma_start,
   output logic [NUM_INPUTS-1:0] winners,
   output logic [CW-1:0]         win_count,
   output logic                  excess,
   output logic [IDX_WIDTH-1:0]  gamma_idx,
   output logic                  result_valid,
   input  logic                  result_ready,
   output logic                  overrun,
   input  logic                  overrun_clr
);

   localparam int PW = (GAMMA_CYCLE_WIDTH > 1) ? $clog2(GAMMA_CYCLE_WIDTH) : 1;
   localparam logic [PW-1:0] PH_LAST     = PW'(GAMMA_CYCLE_WIDTH - 1);
   localparam logic [PW-1:0] PH_RST_LAST = PW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] K_C         = CW'(K);

   typedef enum logic [1:0] {S_IDLE, S_RST, S_SAMPLE} state_t;

   state_t                  r_state, w_next;
   logic [PW-1:0]           r_phase;
   logic [NUM_INPUTS-1:0]   r_acc;
   logic [IDX_WIDTH-1:0]    r_cyc;
   logic [NUM_INPUTS-1:0]   r_winners;
   logic [CW-1:0]           r_win_count;
   logic                    r_excess;
   logic [IDX_WIDTH-1:0]    r_gamma_idx;
   logic                    r_valid;
   logic                    r_overrun;

   logic                    w_col_rst;
   logic                    w_gstart;
   logic                    w_pub;
   logic                    w_xfer;
   logic [NUM_INPUTS-1:0]   w_final;
   logic [CW-1:0]           w_pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (en) w_next = S_RST;
         S_RST:    if (r_phase == PH_RST_LAST) w_next = S_SAMPLE;
         S_SAMPLE: if (r_phase == PH_LAST) w_next = en ? S_RST : S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_col_rst = (r_state != S_SAMPLE);
      w_gstart  = (r_state == S_RST) && (r_phase == '0);
      w_pub     = (r_state == S_SAMPLE) && (r_phase == PH_LAST);
   end

   assign w_xfer  = r_valid & result_ready;
   // The last sample clock's spikes are folded in directly at publish.
   assign w_final = r_acc | col_spikes;

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < NUM_INPUTS; i++) w_pop = w_pop + CW'(w_final[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase <= '0;
         r_acc   <= '0;
      end else begin
         r_phase <= (r_state == S_IDLE || w_pub) ? '0 : r_phase + PW'(1);
         r_acc   <= (r_state == S_SAMPLE && !w_pub) ? w_final : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cyc       <= '0;
         r_winners   <= '0;
         r_win_count <= '0;
         r_excess    <= 1'b0;
         r_gamma_idx <= '0;
         r_valid     <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_pub) begin
            r_winners   <= w_final;
            r_win_count <= w_pop;
            r_excess    <= (w_pop > K_C);
            r_gamma_idx <= r_cyc;
            r_cyc       <= r_cyc + IDX_WIDTH'(1);
            r_valid     <= 1'b1;
         end else if (w_xfer) begin
            r_valid     <= 1'b0;
         end
         // A set on the same edge as a clear must win.
         if (w_pub && r_valid && !w_xfer) r_overrun <= 1'b1;
         else if (overrun_clr)            r_overrun <= 1'b0;
      end
   end

   assign col_rst      = w_col_rst;
   assign gamma_start  = w_gstart;
   assign winners      = r_winners;
   assign win_count    = r_win_count;
   assign excess       = r_excess;
   assign gamma_idx    = r_gamma_idx;
   assign result_valid = r_valid;
   assign overrun      = r_overrun;

endmodule

// File: tb/tb_kwta_gamma_ctrl.sv
// Randomized bench for kwta_gamma_ctrl: a cycle-position model predicts each
// published result into a queue, a monitor pops and compares on every transfer.
module tb_kwta_gamma_ctrl;
   localparam int GCW = 16, RC = 2, NI = 16, KK = 4, IW = 4, CW = 5;

   logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, result_ready = 1'b0, overrun_clr = 1'b0;
   logic [NI-1:0] col_spikes = '0;
   logic          col_rst, gamma_start, excess, result_valid, overrun;
   logic [NI-1:0] winners;
   logic [CW-1:0] win_count;
   logic [IW-1:0] gamma_idx;

   kwta_gamma_ctrl #(.GAMMA_CYCLE_WIDTH(GCW), .RST_CYCLES(RC), .NUM_INPUTS(NI),
                     .K(KK), .IDX_WIDTH(IW)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .col_spikes(col_spikes),
      .col_rst(col_rst), .gamma_start(gamma_start), .winners(winners),
      .win_count(win_count), .excess(excess), .gamma_idx(gamma_idx),
      .result_valid(result_valid), .result_ready(result_ready),
      .overrun(overrun), .overrun_clr(overrun_clr));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NI-1:0] w;
      logic [CW-1:0] c;
      logic          x;
      logic [IW-1:0] idx;
   } res_t;

   res_t q[$];
   int   n_vec = 0, n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: position within the gamma cycle plus a running OR.
   bit            m_run, m_rv, m_ov, m_xfer, m_pub;
   int            m_p;
   logic [NI-1:0] m_acc;
   logic [IW-1:0] m_idx;
   res_t          m_r;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_run = 0; m_p = 0; m_acc = '0; m_idx = '0; m_rv = 0; m_ov = 0;
         q.delete();
      end
      chk("col_rst", col_rst, !(m_run && m_p >= RC));
      chk("gamma_start", gamma_start, m_run && m_p == 0);
      chk("result_valid", result_valid, m_rv);
      chk("overrun", overrun, m_ov);
      if (rst_n) begin
         m_xfer = m_rv && result_ready;
         m_pub  = m_run && m_p == GCW - 1;
         if (m_run && m_p >= RC) m_acc |= col_spikes;
         if (m_pub) begin
            m_r.w   = m_acc;
            m_r.c   = CW'($countones(m_acc));
            m_r.x   = ($countones(m_acc) > KK);
            m_r.idx = m_idx;
            m_idx++;
            if (m_rv && !m_xfer) begin
               m_ov = 1;
               void'(q.pop_back());
            end else if (overrun_clr) m_ov = 0;
            q.push_back(m_r);
            m_rv = 1; m_run = en; m_p = 0; m_acc = '0;
         end else begin
            if (overrun_clr) m_ov = 0;
            if (m_xfer) m_rv = 0;
            if (m_run) m_p++;
            else if (en) begin m_run = 1; m_p = 0; end
         end
      end
   end

   // Monitor: a transfer happens on the coming edge, so check the fields now.
   res_t e;
   always @(negedge clk) begin
      if (rst_n && result_valid && result_ready) begin
         chk("result_expected", q.size() > 0, 1);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("winners", winners, e.w);
            chk("win_count", win_count, e.c);
            chk("excess", excess, e.x);
            chk("gamma_idx", gamma_idx, e.idx);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic rand_spikes();
      case ($urandom_range(0, 7))
         0:       col_spikes = 16'h001F;
         1:       col_spikes = NI'(32'd1 << $urandom_range(0, NI - 1));
         2:       col_spikes = NI'($urandom);
         default: col_spikes = '0;
      endcase
   endtask

   initial begin
      tick(3);
      chk("rst_winners", winners, 0);
      chk("rst_win_count", win_count, 0);
      chk("rst_excess", excess, 0);
      chk("rst_gamma_idx", gamma_idx, 0);
      rst_n = 1; en = 1; result_ready = 1;
      tick(60);
      for (int i = 0; i < 1500; i++) begin
         en           = ($urandom_range(0, 19) != 0);
         result_ready = ($urandom_range(0, 3) != 0);
         overrun_clr  = ($urandom_range(0, 9) == 0);
         rand_spikes();
         tick(1);
      end
      en = 1; overrun_clr = 0; result_ready = 0;
      for (int i = 0; i < 40; i++) begin rand_spikes(); tick(1); end
      overrun_clr = 1; tick(1); overrun_clr = 0;
      result_ready = 1; en = 0;
      for (int i = 0; i < 40; i++) begin rand_spikes(); tick(1); end
      en = 1;
      for (int i = 0; i < 30; i++) begin rand_spikes(); tick(1); end
      result_ready = 0;
      for (int i = 0; i < 25; i++) begin rand_spikes(); tick(1); end
      rst_n = 0;
      #1;
      chk("async_col_rst", col_rst, 1);
      chk("async_result_valid", result_valid, 0);
      tick(2);
      rst_n = 1; result_ready = 1;
      for (int i = 0; i < 300; i++) begin
         result_ready = ($urandom_range(0, 4) != 0);
         rand_spikes();
         tick(1);
      end
      en = 0; result_ready = 1; col_spikes = '0;
      tick(40);
      chk("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
